// File: rtl/mvm_wb_pkg.sv
// Shared definitions for the matrix-vector multiply Wishbone master:
// slave register offsets, the CTRL start bit and the master FSM states.
package mvm_wb_pkg;

  // Register offsets relative to the slave base address
  localparam logic [31:0] OFS_X1   = 32'h0000_0000;
  localparam logic [31:0] OFS_X2   = 32'h0000_0004;
  localparam logic [31:0] OFS_CTRL = 32'h0000_0008;
  localparam logic [31:0] OFS_Y    = 32'h0000_000C;

  // Value written to CTRL to kick off a multiply (bit0 = start)
  localparam logic [31:0] CTRL_START = 32'h0000_0001;

  // Master FSM states: four bus transfers separated by one-cycle gaps
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_X1   = 3'd1,
    WR_X2   = 3'd2,
    WR_CTRL = 3'd3,
    RD_Y    = 3'd4,
    GAP     = 3'd5,
    RESP    = 3'd6
  } state_t;

endpackage

// File: rtl/mvm_wb_master.sv
// Wishbone classic master for the matrix-vector multiply peripheral.
// Each accepted command writes X1, X2 and CTRL.start, then reads Y back and
// returns it on a valid/ready response port. A bus error or an ack timeout
// abandons the remaining transfers and returns an error response instead.
// ROWS*WIDTH_ROWS and COLUMNS*WIDTH_COLUMNS must each fit in 32 bits.
module mvm_wb_master
  import mvm_wb_pkg::*;
#(
  parameter int          ROWS          = 4,
  parameter int          COLUMNS       = 4,
  parameter int          WIDTH_ROWS    = 8,
  parameter int          WIDTH_COLUMNS = 8,
  parameter logic [31:0] BASE_ADDR     = 32'h3000_0000,
  parameter int          TIMEOUT       = 255
) (
  input  logic                             wb_clk_i,
  input  logic                             wb_rst_i,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic [ROWS*WIDTH_ROWS-1:0]       cmd_x1,
  input  logic [COLUMNS*WIDTH_COLUMNS-1:0] cmd_x2,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [ROWS*WIDTH_ROWS-1:0]       rsp_y,
  output logic                             rsp_err,
  output logic                             busy,
  output logic                             wbm_cyc_o,
  output logic                             wbm_stb_o,
  output logic                             wbm_we_o,
  output logic [31:0]                      wbm_adr_o,
  output logic [3:0]                       wbm_sel_o,
  output logic [31:0]                      wbm_dat_o,
  input  logic [31:0]                      wbm_dat_i,
  input  logic                             wbm_ack_i,
  input  logic                             wbm_err_i
);

  localparam int XW = ROWS * WIDTH_ROWS;
  localparam int CW = COLUMNS * WIDTH_COLUMNS;
  // Counter only has to reach TIMEOUT-1; keep at least one bit when disabled
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_t          state;
  state_t          after_gap;
  logic [XW-1:0]   x1_q;
  logic [CW-1:0]   x2_q;
  logic [TW-1:0]   tout_cnt;
  logic            timeout_hit;
  logic            unused_dat_i;

  assign cmd_ready    = (state == IDLE);
  assign busy         = (state != IDLE);
  // Last waiting cycle of a transfer: no ack by the end of it means abort
  assign timeout_hit  = (TIMEOUT != 0) && (tout_cnt == TW'(TIMEOUT - 1));
  // Only the low XW bits of the Y word carry the result
  assign unused_dat_i = ^wbm_dat_i;

  // Command sequencing, Wishbone outputs, timeout counter and response registers
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state     <= IDLE;
      after_gap <= IDLE;
      x1_q      <= '0;
      x2_q      <= '0;
      tout_cnt  <= '0;
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_adr_o <= '0;
      wbm_sel_o <= '0;
      wbm_dat_o <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_y     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            x1_q      <= cmd_x1;
            x2_q      <= cmd_x2;
            state     <= WR_X1;
            tout_cnt  <= '0;
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            wbm_we_o  <= 1'b1;
            wbm_sel_o <= 4'hF;
            wbm_adr_o <= BASE_ADDR + OFS_X1;
            wbm_dat_o <= 32'(cmd_x1);
          end
        end

        WR_X1, WR_X2, WR_CTRL, RD_Y: begin
          if (wbm_err_i) begin
            state     <= RESP;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_sel_o <= '0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_y     <= '0;
          end else if (wbm_ack_i) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_sel_o <= '0;
            case (state)
              WR_X1: begin
                state     <= GAP;
                after_gap <= WR_X2;
              end
              WR_X2: begin
                state     <= GAP;
                after_gap <= WR_CTRL;
              end
              WR_CTRL: begin
                state     <= GAP;
                after_gap <= RD_Y;
              end
              default: begin
                state     <= RESP;
                rsp_valid <= 1'b1;
                rsp_err   <= 1'b0;
                rsp_y     <= wbm_dat_i[XW-1:0];
              end
            endcase
          end else if (timeout_hit) begin
            state     <= RESP;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_sel_o <= '0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_y     <= '0;
          end else begin
            tout_cnt <= tout_cnt + TW'(1);
          end
        end

        GAP: begin
          state     <= after_gap;
          tout_cnt  <= '0;
          wbm_cyc_o <= 1'b1;
          wbm_stb_o <= 1'b1;
          wbm_sel_o <= 4'hF;
          case (after_gap)
            WR_X2: begin
              wbm_we_o  <= 1'b1;
              wbm_adr_o <= BASE_ADDR + OFS_X2;
              wbm_dat_o <= 32'(x2_q);
            end
            WR_CTRL: begin
              wbm_we_o  <= 1'b1;
              wbm_adr_o <= BASE_ADDR + OFS_CTRL;
              wbm_dat_o <= CTRL_START;
            end
            RD_Y: begin
              wbm_we_o  <= 1'b0;
              wbm_adr_o <= BASE_ADDR + OFS_Y;
              wbm_dat_o <= '0;
            end
            default: begin
              state     <= IDLE;
              wbm_cyc_o <= 1'b0;
              wbm_stb_o <= 1'b0;
              wbm_sel_o <= '0;
            end
          endcase
        end

        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mvm_wb_master.sv
// Self-checking bench for mvm_wb_master: table vectors, randomized commands
// against a transfer-level reference model, and hand-written sequences for
// response backpressure and reset in the middle of a command.
module tb_mvm_wb_master;

  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam int          TO   = 8;

  typedef struct {
    logic [31:0] x1;
    logic [31:0] x2;
    logic [31:0] rdata;
    int          w0, w1, w2, w3;
    int          err_idx;
    logic [31:0] exp_y;
    logic        exp_err;
    int          exp_lat;
    int          exp_ntx;
  } vec_t;

  typedef struct {
    logic [31:0] adr;
    logic        we;
    logic [31:0] dat;
    int          len;
  } xfer_t;

  logic        clk = 1'b0;
  logic        wb_rst_i;
  logic        cmd_valid, cmd_ready;
  logic [31:0] cmd_x1, cmd_x2;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_y;
  logic        rsp_err, busy;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i, wbm_err_i;

  int          n_vec  = 0;
  int          n_fail = 0;

  // Slave behaviour knobs and observations
  int          sl_wait [4];
  int          sl_err_idx;
  int          unstable;
  xfer_t       xlog[$];

  vec_t        vecs [6];

  mvm_wb_master #(
    .ROWS(4), .COLUMNS(4), .WIDTH_ROWS(8), .WIDTH_COLUMNS(8),
    .BASE_ADDR(BASE), .TIMEOUT(TO)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(wb_rst_i),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x1(cmd_x1), .cmd_x2(cmd_x2),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_y(rsp_y), .rsp_err(rsp_err), .busy(busy),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_adr_o(wbm_adr_o), .wbm_sel_o(wbm_sel_o), .wbm_dat_o(wbm_dat_o),
    .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got hang expected finish");
    $fatal(1, "[TB] watchdog");
  end

  // Wishbone slave model: waits sl_wait[i] cycles, then acks (and also errs
  // on transfer sl_err_idx); logs every transfer and watches hold stability.
  initial begin
    int          cnt;
    int          k;
    logic        inx;
    xfer_t       cur;
    wbm_ack_i = 1'b0;
    wbm_err_i = 1'b0;
    inx = 1'b0;
    cnt = 0;
    cur = '{adr: 32'h0, we: 1'b0, dat: 32'h0, len: 0};
    forever begin
      @(posedge clk);
      #1;
      if (wbm_cyc_o && wbm_stb_o) begin
        if (!inx) begin
          inx = 1'b1;
          cnt = 0;
          cur.adr = wbm_adr_o;
          cur.we  = wbm_we_o;
          cur.dat = wbm_dat_o;
        end else if (wbm_adr_o != cur.adr || wbm_dat_o != cur.dat || wbm_we_o != cur.we) begin
          unstable++;
        end
        if (wbm_sel_o != 4'hF) unstable++;
        cnt++;
        k = (xlog.size() > 3) ? 3 : xlog.size();
        wbm_ack_i = 1'b0;
        wbm_err_i = 1'b0;
        if (cnt == sl_wait[k] + 1) begin
          wbm_ack_i = 1'b1;
          if (sl_err_idx == xlog.size()) wbm_err_i = 1'b1;
        end
      end else begin
        if (inx) begin
          cur.len = cnt;
          xlog.push_back(cur);
          inx = 1'b0;
        end
        wbm_ack_i = 1'b0;
        wbm_err_i = 1'b0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: what one command should look like on the bus
  function automatic int xfer_len(input int w);
    return (w + 1 > TO) ? TO : w + 1;
  endfunction

  function automatic void model(input vec_t v, output vec_t r);
    int w [4];
    r = v;
    w[0] = v.w0; w[1] = v.w1; w[2] = v.w2; w[3] = v.w3;
    r.exp_lat = 0;
    r.exp_ntx = 0;
    r.exp_err = 1'b0;
    for (int i = 0; i < 4; i++) begin
      r.exp_lat += xfer_len(w[i]);
      r.exp_ntx++;
      if (i == v.err_idx || w[i] >= TO) begin
        r.exp_err = 1'b1;
        break;
      end
      if (i < 3) r.exp_lat += 1;
    end
    r.exp_lat += 1;
    r.exp_y = r.exp_err ? 32'h0 : v.rdata;
  endfunction

  function automatic xfer_t model_xfer(input vec_t v, input int i);
    xfer_t t;
    int    w [4];
    w[0] = v.w0; w[1] = v.w1; w[2] = v.w2; w[3] = v.w3;
    t.adr = BASE + 32'(4 * i);
    t.we  = (i < 3);
    t.dat = (i == 0) ? v.x1 : (i == 1) ? v.x2 : (i == 2) ? 32'h1 : 32'h0;
    t.len = xfer_len(w[i]);
    return t;
  endfunction

  // Issue one command (caller sits at a negedge) and check it up to the
  // first cycle of rsp_valid; the response is left pending.
  task automatic applyStimulus(input vec_t v);
    int    n;
    xfer_t e;
    xlog.delete();
    unstable   = 0;
    sl_wait[0] = v.w0; sl_wait[1] = v.w1; sl_wait[2] = v.w2; sl_wait[3] = v.w3;
    sl_err_idx = v.err_idx;
    wbm_dat_i  = v.rdata;
    cmd_x1     = v.x1;
    cmd_x2     = v.x2;
    cmd_valid  = 1'b1;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("cmd_ready_idle", 32'(cmd_ready), 32'h1);
    @(posedge clk);
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        cmd_valid = 1'b0;
        checkOutput("busy_after_accept", 32'(busy), 32'h1);
        checkOutput("cmd_ready_busy", 32'(cmd_ready), 32'h0);
      end
      if (rsp_valid) break;
    end
    checkOutput("rsp_latency", 32'(n), 32'(v.exp_lat));
    checkOutput("rsp_err", 32'(rsp_err), 32'(v.exp_err));
    checkOutput("rsp_y", rsp_y, v.exp_y);
    checkOutput("num_transfers", 32'(xlog.size()), 32'(v.exp_ntx));
    for (int i = 0; i < v.exp_ntx && i < xlog.size(); i++) begin
      e = model_xfer(v, i);
      checkOutput($sformatf("xfer%0d_adr", i), xlog[i].adr, e.adr);
      checkOutput($sformatf("xfer%0d_we", i), 32'(xlog[i].we), 32'(e.we));
      checkOutput($sformatf("xfer%0d_dat", i), xlog[i].dat, e.dat);
      checkOutput($sformatf("xfer%0d_stb_cycles", i), 32'(xlog[i].len), 32'(e.len));
    end
    checkOutput("hold_stable", 32'(unstable), 32'h0);
  endtask

  task automatic consumeResponse();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checkOutput("rsp_valid_after_hs", 32'(rsp_valid), 32'h0);
    checkOutput("busy_after_hs", 32'(busy), 32'h0);
  endtask

  initial begin
    vec_t v;
    vec_t r;
    int   n;
    logic seen;

    // x1, x2, rdata, waits, err_idx, exp_y, exp_err, exp_lat, exp_ntx
    vecs[0] = '{32'h01020304, 32'h01010101, 32'hDEADBEEF, 0, 0, 0, 0, -1, 32'hDEADBEEF, 1'b0, 8, 4};
    vecs[1] = '{32'hA5A5A5A5, 32'h5A5A5A5A, 32'h12345678, 3, 3, 3, 3, -1, 32'h12345678, 1'b0, 20, 4};
    vecs[2] = '{32'h11111111, 32'h22222222, 32'hCAFEF00D, 0, 0, 0, 0, 1, 32'h0, 1'b1, 4, 2};
    vecs[3] = '{32'h33333333, 32'h44444444, 32'hCAFEF00D, 20, 0, 0, 0, -1, 32'h0, 1'b1, 9, 1};
    vecs[4] = '{32'h0000FFFF, 32'hFFFF0000, 32'h87654321, 7, 0, 0, 0, -1, 32'h87654321, 1'b0, 15, 4};
    vecs[5] = '{32'h55AA55AA, 32'h0F0F0F0F, 32'h13579BDF, 0, 0, 0, 2, 3, 32'h0, 1'b1, 10, 4};

    wb_rst_i   = 1'b1;
    cmd_valid  = 1'b0;
    cmd_x1     = '0;
    cmd_x2     = '0;
    rsp_ready  = 1'b0;
    wbm_dat_i  = '0;
    sl_err_idx = -1;
    for (int i = 0; i < 4; i++) sl_wait[i] = 0;
    unstable   = 0;

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rst_cyc", 32'(wbm_cyc_o), 32'h0);
    checkOutput("rst_stb", 32'(wbm_stb_o), 32'h0);
    checkOutput("rst_we", 32'(wbm_we_o), 32'h0);
    checkOutput("rst_adr", wbm_adr_o, 32'h0);
    checkOutput("rst_dat", wbm_dat_o, 32'h0);
    checkOutput("rst_sel", 32'(wbm_sel_o), 32'h0);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    checkOutput("rst_rsp_err", 32'(rsp_err), 32'h0);
    checkOutput("rst_rsp_y", rsp_y, 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    wb_rst_i = 1'b0;
    @(negedge clk);
    checkOutput("idle_cmd_ready", 32'(cmd_ready), 32'h1);

    // Table vectors
    for (int i = 0; i < 6; i++) begin
      $display("[TB] table vector %0d", i);
      applyStimulus(vecs[i]);
      consumeResponse();
    end

    // Randomized commands checked against the model
    for (int i = 0; i < 30; i++) begin
      v.x1    = $urandom;
      v.x2    = $urandom;
      v.rdata = $urandom;
      v.w0    = $urandom_range(0, 9);
      v.w1    = $urandom_range(0, 9);
      v.w2    = $urandom_range(0, 9);
      v.w3    = $urandom_range(0, 9);
      n       = $urandom_range(0, 9);
      v.err_idx = (n < 4) ? n : -1;
      model(v, r);
      applyStimulus(r);
      consumeResponse();
    end

    // Response backpressure with a new command already waiting
    $display("[TB] backpressure sequence");
    applyStimulus(vecs[0]);
    cmd_x1    = 32'h0BADCAFE;
    cmd_x2    = 32'h00C0FFEE;
    cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bp_rsp_valid", 32'(rsp_valid), 32'h1);
      checkOutput("bp_rsp_y", rsp_y, 32'hDEADBEEF);
      checkOutput("bp_cmd_ready", 32'(cmd_ready), 32'h0);
    end
    xlog.delete();
    wbm_dat_i = 32'h2468ACE0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checkOutput("bp_rsp_valid_dropped", 32'(rsp_valid), 32'h0);
    checkOutput("bp_cmd_ready_after", 32'(cmd_ready), 32'h1);
    @(negedge clk);
    cmd_valid = 1'b0;
    checkOutput("bp_next_stb", 32'(wbm_stb_o), 32'h1);
    checkOutput("bp_next_adr", wbm_adr_o, BASE);
    checkOutput("bp_next_dat", wbm_dat_o, 32'h0BADCAFE);
    n = 0;
    while (!rsp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("bp_next_rsp_valid", 32'(rsp_valid), 32'h1);
    checkOutput("bp_next_rsp_y", rsp_y, 32'h2468ACE0);
    consumeResponse();

    // Reset while the CTRL write is on the bus
    $display("[TB] reset during CTRL sequence");
    xlog.delete();
    for (int i = 0; i < 4; i++) sl_wait[i] = 0;
    sl_err_idx = -1;
    cmd_x1     = 32'h76543210;
    cmd_x2     = 32'hFEDCBA98;
    cmd_valid  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 30) begin
      if (wbm_stb_o && wbm_adr_o == BASE + 32'h8) seen = 1'b1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    checkOutput("rst_ctrl_reached", 32'(seen), 32'h1);
    wb_rst_i = 1'b1;
    @(negedge clk);
    checkOutput("midrst_cyc", 32'(wbm_cyc_o), 32'h0);
    checkOutput("midrst_stb", 32'(wbm_stb_o), 32'h0);
    checkOutput("midrst_busy", 32'(busy), 32'h0);
    wb_rst_i = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid || wbm_stb_o) seen = 1'b1;
    end
    checkOutput("midrst_no_response", 32'(seen), 32'h0);
    applyStimulus(vecs[0]);
    consumeResponse();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/mvm_wb_master.md
Name: mvm_wb_master

Overview:
- Wishbone classic master that drives the matrix-vector multiply peripheral's Wishbone slave from a simple command interface.
- Per command it performs four single transfers: write x1 operand, write x2 operand, write the control start bit, then read the result vector y.
- The result returns on a valid/ready response port.
- Used as the test/host-side initiator in the wishbone_slave simulation and as the on-chip driver for the accelerator.

Parameters:
- ROWS, 4, vector elements in x1/y.
- COLUMNS, 4, vector elements in x2.
- WIDTH_ROWS, 8, bits per x1/y element. ROWS*WIDTH_ROWS must be <= 32.
- WIDTH_COLUMNS, 8, bits per x2 element. COLUMNS*WIDTH_COLUMNS must be <= 32.
- BASE_ADDR, 32'h3000_0000, slave base address.
- TIMEOUT, 255, max cycles to wait for ack per transfer. 0 disables the timeout.

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_i  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when both valid and ready are high.
- cmd_x1  in  ROWS*WIDTH_ROWS  packed x1 operand.
- cmd_x2  in  COLUMNS*WIDTH_COLUMNS  packed x2 operand.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_y  out  ROWS*WIDTH_ROWS  result vector.
- rsp_err  out  1  transfer aborted (bus error or timeout).
- busy  out  1  high in every state except IDLE.
- wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1 each  Wishbone control.
- wbm_adr_o  out  32  address.
- wbm_sel_o  out  4  byte select, always 4'hF during a transfer.
- wbm_dat_o  out  32  write data.
- wbm_dat_i  in  32  read data.
- wbm_ack_i, wbm_err_i  in  1 each  slave response.

Behaviour:
- Slave register map, as offsets from BASE_ADDR:
  - 0x00 X1 (write)
  - 0x04 X2 (write)
  - 0x08 CTRL (write; bit0 = start)
  - 0x0C Y (read)
- States: IDLE, WR_X1, WR_X2, WR_CTRL, RD_Y, GAP, RESP.
- Reset (sync, wb_rst_i=1 at clock edge):
  - Next state is IDLE.
  - cyc, stb, we, rsp_valid, rsp_err and busy are all 0.
  - rsp_y, adr, dat_o and sel are 0.
  - Reset mid-transfer drops cyc/stb at that same edge. The transfer is abandoned and no response is produced.
- IDLE: cmd_ready=1. On handshake, cmd_x1 and cmd_x2 are latched and the next state is WR_X1. cmd_ready=0 in all other states.
- Transfer states: all Wishbone outputs are registered; cyc=stb=1.
  - WR_X1: we=1, dat_o = zero-extended x1.
  - WR_X2: we=1, dat_o = zero-extended x2.
  - WR_CTRL: we=1, dat_o = 32'h1.
  - RD_Y: we=0, dat_o = 0.
  - Outputs are held stable until ack or err is sampled high.
- On ack: cyc/stb deassert at the next edge and the FSM enters GAP for exactly one cycle, then moves to the next transfer. After RD_Y it goes to RESP instead of GAP.
- RD_Y ack: rsp_y <= wbm_dat_i[ROWS*WIDTH_ROWS-1:0], rsp_err <= 0.
- err, or timeout, in any transfer state: cyc/stb drop, remaining transfers are skipped, and the FSM goes to RESP with rsp_err=1 and rsp_y=0.
- Timeout: a per-transfer counter clears when a transfer starts and increments each cycle stb is high without ack or err. Reaching TIMEOUT aborts the transfer. If ack and timeout coincide, ack wins. If ack and err coincide, err wins.
- RESP: rsp_valid=1, with rsp_y and rsp_err held until rsp_ready. On handshake the FSM returns to IDLE. A new command can be accepted no earlier than the cycle after that.
- ack or err seen while cyc=0 is ignored.
- Minimum latency (slave acks in the first stb cycle), command accepted at edge T:
  - stb high in cycles T+1 (X1), T+3 (X2), T+5 (CTRL), T+7 (Y).
  - rsp_valid high from T+8.

Decomposition:
- Package mvm_wb_pkg holds:
  - register offsets: OFS_X1, OFS_X2, OFS_CTRL, OFS_Y;
  - the CTRL start-bit constant;
  - the state enumeration/encoding.
- Single module. No sub-module is needed; the timeout counter stays inline.

Test Plan:
- Zero-wait slave; x1=32'h01020304, x2=32'h01010101 -> writes at 0x3000_0000/04/08 with data 01020304/01010101/00000001, read at 0x0C. rsp_valid at T+8 with rsp_y equal to the slave's returned word and rsp_err=0.
- Slave inserts 3 wait states per transfer -> address and data stable throughout each wait; rsp_valid at T+20; counter never aborts.
- wbm_err_i on the X2 write -> no CTRL or Y transfer occurs; rsp_valid=1, rsp_err=1, rsp_y=0.
- Slave never acks, TIMEOUT=8 -> stb drops after 8 cycles on the X1 transfer; rsp_err=1.
- rsp_ready held low 5 cycles; cmd_valid held high -> response stable, cmd_ready=0 until the rsp handshake, and the next command is accepted the cycle after.
- wb_rst_i asserted during WR_CTRL -> cyc/stb low at that edge, busy=0, no response; a following command completes normally.
